// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator: game mode codes, melody
// lengths, the note-code type and the note-to-half-period function.
package tone_pkg;

    localparam logic [3:0] MODE_GAMESTART = 4'd0;
    localparam logic [3:0] MODE_EASY      = 4'd1;
    localparam logic [3:0] MODE_NORMAL    = 4'd2;
    localparam logic [3:0] MODE_HARD      = 4'd3;
    localparam logic [3:0] MODE_INFERNO   = 4'd4;
    localparam logic [3:0] MODE_FAILURE   = 4'd5;

    localparam logic [11:0] START_LEN = 12'd256;
    localparam logic [11:0] STAGE_LEN = 12'd512;
    localparam logic [11:0] FAIL_LEN  = 12'd128;

    // Note code: 0 is a rest, 1..48 are C3..B6 in semitone steps.
    typedef logic [5:0] note_t;

    localparam note_t NOTE_REST = 6'd0;
    localparam note_t NOTE_MAX  = 6'd48;

    localparam logic signed [15:0] DEF_AMP = 16'sh2000;

    // Half-period in clock cycles for a note code, truncated toward zero.
    // Only ever called with constant arguments, so it folds into a table.
    // Octave-3 frequencies are held in micro-hertz to keep the truncated
    // result exact for the usual 100 MHz system clock.
    function automatic logic [19:0] note_half(input longint clk_hz, input note_t code);
        longint f_uhz;
        int     idx;
        if (code == NOTE_REST || code > NOTE_MAX) begin
            return 20'd0;
        end
        idx = int'(code) - 1;
        case (idx % 12)
            0:       f_uhz = 130812783;
            1:       f_uhz = 138591315;
            2:       f_uhz = 146832384;
            3:       f_uhz = 155563492;
            4:       f_uhz = 164813778;
            5:       f_uhz = 174614116;
            6:       f_uhz = 184997211;
            7:       f_uhz = 195997718;
            8:       f_uhz = 207652349;
            9:       f_uhz = 220000000;
            10:      f_uhz = 233081881;
            default: f_uhz = 246941651;
        endcase
        f_uhz = f_uhz << (idx / 12);
        return 20'((clk_hz * 1000000) / (2 * f_uhz));
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational melody lookup: (mode, beat) -> note code.
// Beats at or past a melody's length, and unknown modes, are rests.
module melody_rom
    import tone_pkg::*;
(
    input  logic [3:0]  mode_i,
    input  logic [11:0] beat_i,
    output note_t       note_o
);

    // Title-screen melody: eight-beat arpeggio.
    function automatic note_t start_note(input logic [2:0] idx);
        case (idx)
            3'd0:    return 6'd13;
            3'd1:    return 6'd17;
            3'd2:    return 6'd20;
            3'd3:    return 6'd25;
            3'd4:    return 6'd20;
            3'd5:    return 6'd17;
            3'd6:    return 6'd13;
            default: return NOTE_REST;
        endcase
    endfunction

    // Stage melody: a sixteen-beat phrase with an alternate answer phrase.
    function automatic note_t stage_note(input logic [3:0] idx, input logic alt);
        if (!alt) begin
            case (idx)
                4'd0:    return 6'd22;
                4'd1:    return 6'd25;
                4'd2:    return 6'd27;
                4'd3:    return 6'd25;
                4'd4:    return 6'd22;
                4'd5:    return 6'd17;
                4'd6:    return 6'd17;
                4'd7:    return 6'd20;
                4'd8:    return 6'd22;
                4'd9:    return NOTE_REST;
                4'd10:   return 6'd22;
                4'd11:   return 6'd25;
                4'd12:   return 6'd24;
                4'd13:   return 6'd20;
                4'd14:   return 6'd17;
                default: return NOTE_REST;
            endcase
        end
        case (idx)
            4'd0:    return 6'd29;
            4'd1:    return 6'd27;
            4'd2:    return 6'd25;
            4'd3:    return 6'd24;
            4'd4:    return 6'd22;
            4'd5:    return 6'd20;
            4'd6:    return 6'd17;
            4'd7:    return NOTE_REST;
            4'd8:    return 6'd25;
            4'd9:    return 6'd24;
            4'd10:   return 6'd22;
            4'd11:   return 6'd20;
            4'd12:   return 6'd17;
            4'd13:   return 6'd15;
            4'd14:   return 6'd17;
            default: return NOTE_REST;
        endcase
    endfunction

    // Failure jingle: descending chromatic run then silence.
    function automatic note_t fail_note(input logic [2:0] idx);
        case (idx)
            3'd0:    return 6'd17;
            3'd1:    return 6'd16;
            3'd2:    return 6'd15;
            3'd3:    return 6'd14;
            3'd4:    return 6'd13;
            default: return NOTE_REST;
        endcase
    endfunction

    // Select the melody for the mode and blank beats past its end.
    always_comb begin
        note_o = NOTE_REST;
        case (mode_i)
            MODE_GAMESTART: begin
                if (beat_i < START_LEN) note_o = start_note(beat_i[2:0]);
            end
            MODE_EASY, MODE_NORMAL, MODE_HARD, MODE_INFERNO: begin
                if (beat_i < STAGE_LEN) note_o = stage_note(beat_i[3:0], beat_i[6]);
            end
            MODE_FAILURE: begin
                if (beat_i < FAIL_LEN) note_o = fail_note(beat_i[2:0]);
            end
            default: note_o = NOTE_REST;
        endcase
    end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator driven by the beat index and game mode.
// Optional build macro TONE_GEN_ARTIC_EN: when defined, a note repeated on
// consecutive beats is re-struck with a GAP_CYCLES silence and a phase
// restart; when undefined the repeated note simply sustains.
module tone_gen
    import tone_pkg::*;
#(
    parameter int                 CLK_HZ     = 100_000_000,
    parameter logic signed [15:0] AMP        = DEF_AMP,
    parameter int                 GAP_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         mode,
    input  logic [11:0]        ibeat,
    input  logic               mute,
    output logic signed [15:0] audio_left,
    output logic signed [15:0] audio_right,
    output logic               beat_tick
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [11:0]        s0_q, s1_q, cur_beat_q;
    logic               beat_tick_q;
    logic [19:0]        active_half_q, active_half_d;
    logic [19:0]        cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic signed [15:0] audio_q;

    note_t       note;
    logic [19:0] half_tbl [64];
    logic [19:0] base_half, target_half;
    logic        accept, restrike, gap_active;

    melody_rom u_melody_rom (
        .mode_i (mode),
        .beat_i (cur_beat_q),
        .note_o (note)
    );

    for (genvar g = 0; g < 64; g++) begin : g_half
        localparam logic [19:0] HALF = note_half(longint'(CLK_HZ), note_t'(g));
        assign half_tbl[g] = HALF;
    end

    assign base_half   = half_tbl[note];
    assign target_half = (mode == MODE_HARD || mode == MODE_INFERNO) ? (base_half >> 1) : base_half;

    // A beat is taken only once two consecutive samples agree, which rejects
    // skew between bits of the quasi-static ibeat bus.
    assign accept = (s0_q == s1_q) && (s0_q != cur_beat_q);

    // Two-stage beat sampler and accepted-beat register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q        <= '0;
            s1_q        <= '0;
            cur_beat_q  <= '0;
            beat_tick_q <= 1'b0;
        end else begin
            s0_q        <= ibeat;
            s1_q        <= s0_q;
            beat_tick_q <= accept;
            if (accept) cur_beat_q <= s0_q;
        end
    end

`ifdef TONE_GEN_ARTIC_EN
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    assign restrike   = beat_tick_q && (target_half == active_half_q);
    assign gap_active = (gap_cnt_q != '0);

    // Gap timer: reloaded by a re-strike, cancelled by any new note.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (restrike) begin
            gap_cnt_d = GAP_W'(GAP_CYCLES);
        end else if (target_half != active_half_q) begin
            gap_cnt_d = '0;
        end else if (gap_active) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
    end

    // Gap timer register.
    always_ff @(posedge clk) begin
        if (reset) gap_cnt_q <= '0;
        else       gap_cnt_q <= gap_cnt_d;
    end
`else
    logic [GAP_W-1:0] gap_unused;

    assign gap_unused = '0;
    assign restrike   = 1'b0;
    assign gap_active = 1'b0;
`endif

    // Tone phase accumulator: reload on note change, hold during a gap,
    // otherwise count half-periods and flip the phase at each wrap.
    always_comb begin
        active_half_d = active_half_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        if (restrike) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (target_half != active_half_q) begin
            active_half_d = target_half;
            cnt_d         = '0;
            phase_d       = 1'b0;
        end else if (!gap_active && active_half_q != '0) begin
            if (cnt_q == active_half_q - 20'd1) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    // Tone state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_half_q <= '0;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
        end else begin
            active_half_q <= active_half_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
        end
    end

    // Output sample register; mute only blanks the sample, never the phase.
    always_ff @(posedge clk) begin
        if (reset || active_half_q == '0 || gap_active || mute) begin
            audio_q <= '0;
        end else begin
            audio_q <= phase_q ? AMP : -AMP;
        end
    end

    assign audio_left  = audio_q;
    assign audio_right = audio_q;
    assign beat_tick   = beat_tick_q;

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen. Stimulus pushes per-cycle expected samples
// and expected beat_tick cycles; monitors pop and compare on the falling edge.
module tb_tone_gen;

    localparam int CLK_HZ = 100_000;
    localparam int GAP    = 300;
    localparam logic signed [15:0] AMP = 16'sh2000;
    // Half-periods at 100 kHz: A4 440 Hz, C5 523.25 Hz, E4 329.63 Hz, A4 up an octave.
    localparam int H_A4    = 113;
    localparam int H_C5    = 95;
    localparam int H_E4    = 151;
    localparam int H_A4_HI = 56;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         mode;
    logic [11:0]        ibeat;
    logic               mute;
    logic signed [15:0] audio_left;
    logic signed [15:0] audio_right;
    logic               beat_tick;

    tone_gen #(
        .CLK_HZ     (CLK_HZ),
        .AMP        (AMP),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .ibeat       (ibeat),
        .mute        (mute),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .beat_tick   (beat_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        logic signed [15:0] val;
    } aexp_t;

    aexp_t aq[$];
    int    tq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Expected-waveform descriptor: silence, or a square wave whose first
    // low sample is at cycle d_c0 (silence before that), optionally muted.
    int chk_end = 0;
    bit d_tone  = 1'b0;
    int d_c0    = 0;
    int d_half  = 1;
    bit d_mute  = 1'b0;

    function automatic logic signed [15:0] model_at(input int c);
        if (!d_tone || d_mute || c < d_c0) return 16'sd0;
        return (((c - d_c0) / d_half) % 2 == 1) ? AMP : -AMP;
    endfunction

    task automatic advance(input int upto);
        while (chk_end < upto) begin
            chk_end++;
            aq.push_back('{chk_end, model_at(chk_end)});
        end
    endtask

    task automatic run(input int n);
        advance(cyc + n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_tone(input int c0, input int half);
        d_tone = 1'b1;
        d_c0   = c0;
        d_half = half;
    endtask

    // half > 0: new note, half == 0: rest, half < 0: same note repeated.
    task automatic new_beat(input int b, input int half);
        int t;
        t = cyc;
        ibeat = 12'(b);
        tq.push_back(t + 3);
        advance(t + 4);
        if (half == 0) begin
            d_tone = 1'b0;
        end else if (half > 0) begin
            set_tone(t + 5, half);
        end else begin
`ifdef TONE_GEN_ARTIC_EN
            set_tone(t + 5 + GAP, d_half);
`endif
        end
    endtask

    task automatic set_mode(input int m, input int half);
        int t;
        t = cyc;
        mode = 4'(m);
        advance(t + 1);
        if (half == 0) d_tone = 1'b0;
        else           set_tone(t + 2, half);
    endtask

    task automatic release_reset(input int half);
        reset = 1'b0;
        advance(cyc + 1);
        set_tone(cyc + 2, half);
    endtask

    aexp_t e;
    int    te;

    // Audio monitor: compares every cycle that has an expectation queued.
    always @(negedge clk) begin
        if (cyc > 0) begin
            while (aq.size() > 0 && aq[0].cyc < cyc) begin
                e = aq.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL audio_skipped cyc=%0d", e.cyc);
            end
            if (aq.size() > 0 && aq[0].cyc == cyc) begin
                e = aq.pop_front();
                n_checks++;
                if (audio_left !== e.val) begin
                    n_fail++;
                    $display("FAIL audio_left cyc=%0d got=%0d exp=%0d", cyc, audio_left, e.val);
                end
                n_checks++;
                if (audio_right !== e.val) begin
                    n_fail++;
                    $display("FAIL audio_right cyc=%0d got=%0d exp=%0d", cyc, audio_right, e.val);
                end
            end
        end
    end

    // Beat-tick monitor: every pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            while (tq.size() > 0 && tq[0] < cyc) begin
                te = tq.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL beat_tick_missing got=none exp_cyc=%0d", te);
            end
            if (beat_tick !== 1'b0) begin
                n_checks++;
                if (tq.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_tick_unexpected got_cyc=%0d exp=none val=%b", cyc, beat_tick);
                end else begin
                    te = tq.pop_front();
                    if (te != cyc || beat_tick !== 1'b1) begin
                        n_fail++;
                        $display("FAIL beat_tick_cycle got_cyc=%0d exp_cyc=%0d", cyc, te);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mode  = 4'd1;
        ibeat = 12'd0;
        mute  = 1'b0;
        run(5);
        release_reset(H_A4);
        run(300);

        new_beat(1, H_C5);
        run(250);

        ibeat = 12'd7;
        run(1);
        ibeat = 12'd1;
        run(200);

        new_beat(5, H_E4);
        run(400);
        new_beat(6, -1);
        run(GAP + 300);

        new_beat(0, H_A4);
        run(300);
        set_mode(3, H_A4_HI);
        run(300);

        mute   = 1'b1;
        d_mute = 1'b1;
        run(1000);
        mute   = 1'b0;
        d_mute = 1'b0;
        run(300);

        set_mode(2, H_A4);
        run(100);
        new_beat(512, 0);
        run(100);
        new_beat(1, H_C5);
        run(150);
        set_mode(9, 0);
        run(100);

        set_mode(1, H_C5);
        run(100);
        new_beat(5, H_E4);
        run(200);
        new_beat(6, -1);
        run(100);
        reset  = 1'b1;
        ibeat  = 12'd0;
        d_tone = 1'b0;
        run(3);
        release_reset(H_A4);
        run(300);

        @(negedge clk);
        #1;
        n_checks++;
        if (aq.size() != 0 || tq.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained got_audio=%0d got_tick=%0d exp=0", aq.size(), tq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
